// File: rtl/dtfag_agu_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dtfag_agu_param: radix-2^LOG_R DIF FFT/NTT twiddle exponent generator     |
// | with run control, valid/ready backpressure and inverse mode. Rev 1.0      |
// +--------------------------------------------------------------------------+
module dtfag_agu_param #(
  parameter int LOG_N   = 16,
  parameter int LOG_R   = 4,
  parameter int NUM_ROM = 4,
  localparam int STAGES = LOG_N / LOG_R,
  localparam int ROM_AW = LOG_N / NUM_ROM,
  localparam int SW     = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int BW     = LOG_N - LOG_R
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_inv,
  output logic                      o_busy,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [LOG_N-1:0]          o_out_exp,
  output logic [NUM_ROM*ROM_AW-1:0] o_out_ma,
  output logic [SW-1:0]             o_out_stage,
  output logic [BW-1:0]             o_out_bfly,
  output logic [LOG_R-1:0]          o_out_lane,
  output logic                      o_out_last,
  output logic                      o_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic             r_inv;
  logic             r_done;
  logic [SW-1:0]    r_s;
  logic [BW-1:0]    r_b;
  logic [LOG_R-1:0] r_k;
  logic [LOG_N-1:0] r_e;
  logic [LOG_N-1:0] r_step;
  logic [LOG_N-1:0] r_exp;

  logic             w_acc;
  logic             w_last;
  logic             w_wrap_k;
  logic [SW-1:0]    w_s_nxt;
  logic [BW-1:0]    w_b_nxt;
  logic [LOG_R-1:0] w_k_nxt;
  logic [LOG_N-1:0] w_step_nxt;
  logic [LOG_N-1:0] w_e_inc;
  logic [LOG_N-1:0] w_e_neg;

  // step = (b mod N/R^(s+1)) * R^s, truncated to LOG_N bits
  function automatic logic [LOG_N-1:0] f_step(input logic [SW-1:0] s, input logic [BW-1:0] b);
    logic [LOG_N-1:0] mask;
    mask = {LOG_N{1'b1}} >> (LOG_R * (int'(s) + 1));
    return (LOG_N'(b) & mask) << (LOG_R * int'(s));
  endfunction

  assign w_acc    = (r_state == ST_RUN) && i_out_ready;
  assign w_wrap_k = &r_k;
  assign w_last   = (r_s == SW'(STAGES - 1)) && (&r_b) && w_wrap_k;
  assign w_e_inc  = r_e + r_step;
  assign w_e_neg  = LOG_N'(0) - w_e_inc;

  always_comb begin
    w_k_nxt = r_k + LOG_R'(1);
    w_b_nxt = r_b;
    w_s_nxt = r_s;
    if (w_wrap_k) begin
      w_k_nxt = '0;
      w_b_nxt = r_b + BW'(1);
      if (&r_b) begin
        w_b_nxt = '0;
        w_s_nxt = r_s + SW'(1);
      end
    end
  end

  assign w_step_nxt = f_step(w_s_nxt, w_b_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_inv   <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_e     <= '0;
      r_step  <= '0;
      r_exp   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_inv   <= i_inv;
            r_s     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_e     <= '0;
            r_step  <= '0;
            r_exp   <= '0;
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_s     <= '0;
              r_b     <= '0;
              r_k     <= '0;
              r_e     <= '0;
              r_step  <= '0;
              r_exp   <= '0;
            end else begin
              r_s <= w_s_nxt;
              r_b <= w_b_nxt;
              r_k <= w_k_nxt;
              // Lane 0 of every butterfly has exponent 0, so the accumulator restarts
              if (w_wrap_k) begin
                r_e    <= '0;
                r_step <= w_step_nxt;
                r_exp  <= '0;
              end else begin
                r_e   <= w_e_inc;
                r_exp <= r_inv ? w_e_neg : w_e_inc;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar m = 0; m < NUM_ROM; m++) begin : g_ma
    assign o_out_ma[m*ROM_AW +: ROM_AW] = r_exp[m*ROM_AW +: ROM_AW];
  end

  assign o_busy      = (r_state == ST_RUN);
  assign o_out_valid = (r_state == ST_RUN);
  assign o_out_exp   = r_exp;
  assign o_out_stage = r_s;
  assign o_out_bfly  = r_b;
  assign o_out_lane  = r_k;
  assign o_out_last  = (r_state == ST_RUN) && w_last;
  assign o_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dtfag_agu_param.sv
`default_nettype none
// Testbench for dtfag_agu_param: default-size instance for early beats, reset and
// inverse; a 4096-point instance for complete runs under random backpressure.
module tb_dtfag_agu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default configuration N=65536, R=16
  logic        b_rst, b_start, b_inv, b_rdy;
  logic        b_busy, b_valid, b_last, b_done;
  logic [15:0] b_exp, b_ma;
  logic [1:0]  b_stage;
  logic [11:0] b_bfly;
  logic [3:0]  b_lane;

  dtfag_agu_param #(.LOG_N(16), .LOG_R(4), .NUM_ROM(4)) u_big (
    .clk(clk), .rst(b_rst), .i_start(b_start), .i_inv(b_inv), .o_busy(b_busy),
    .o_out_valid(b_valid), .i_out_ready(b_rdy), .o_out_exp(b_exp), .o_out_ma(b_ma),
    .o_out_stage(b_stage), .o_out_bfly(b_bfly), .o_out_lane(b_lane),
    .o_out_last(b_last), .o_done(b_done)
  );

  // Reduced configuration N=4096, R=16, 3 stages
  logic        s_rst, s_start, s_inv, s_rdy;
  logic        s_busy, s_valid, s_last, s_done;
  logic [11:0] s_exp, s_ma;
  logic [1:0]  s_stage;
  logic [7:0]  s_bfly;
  logic [3:0]  s_lane;

  dtfag_agu_param #(.LOG_N(12), .LOG_R(4), .NUM_ROM(4)) u_sml (
    .clk(clk), .rst(s_rst), .i_start(s_start), .i_inv(s_inv), .o_busy(s_busy),
    .o_out_valid(s_valid), .i_out_ready(s_rdy), .o_out_exp(s_exp), .o_out_ma(s_ma),
    .o_out_stage(s_stage), .o_out_bfly(s_bfly), .o_out_lane(s_lane),
    .o_out_last(s_last), .o_done(s_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Beat number -> (s,b,k) and exponent straight from the transform definition
  function automatic void f_model(input int log_n, input int log_r, input longint n,
                                  input bit inv, output longint e, output longint s,
                                  output longint b, output longint k);
    longint nn, rr, rs, p;
    nn = longint'(1) << log_n;
    rr = longint'(1) << log_r;
    s  = n / nn;
    b  = (n % nn) / rr;
    k  = n % rr;
    rs = 1;
    for (int i = 0; i < s; i++) rs = rs * rr;
    p  = b % (nn / (rs * rr));
    e  = (p * k * rs) % nn;
    if (inv) e = (nn - e) % nn;
  endfunction

  // Consume beats of the default instance until beat stop_at is on the outputs
  task automatic big_run(input bit inv_mode, input int stop_at);
    longint e, s, b, k;
    int n = 0;
    int cyc = 0;
    while (n < stop_at && cyc < stop_at * 4 + 100) begin
      f_model(16, 4, n, inv_mode, e, s, b, k);
      chk("big_beat", {b_exp, b_stage, b_bfly, b_lane, b_last, b_valid, b_busy, b_done},
          {16'(e), 2'(s), 12'(b), 4'(k), 1'b0, 3'b110});
      chk("big_ma", b_ma, e);
      if (n == 17) chk("big_b1k1", b_exp, inv_mode ? 16'hFFFF : 16'h0001);
      if (n == 50) b_inv = ~inv_mode;
      b_start = (n == 100);
      b_rdy = ($urandom_range(0, 99) >= 30);
      if (b_rdy) n++;
      @(negedge clk);
      cyc++;
    end
    b_start = 1'b0;
    chk("big_run_timeout", n, stop_at);
  endtask

  // One complete run of the reduced instance; optionally restart in the done cycle
  task automatic sml_run(input bit inv_mode, input bit chain);
    localparam int TOT = 3 * 4096;
    longint e, s, b, k;
    int n = 0;
    int cyc = 0;
    while (n < TOT && cyc < TOT * 4 + 100) begin
      f_model(12, 4, n, inv_mode, e, s, b, k);
      chk("sml_beat", {s_exp, s_stage, s_bfly, s_lane, s_last, s_valid, s_busy, s_done},
          {12'(e), 2'(s), 8'(b), 4'(k), (n == TOT - 1), 3'b110});
      chk("sml_ma", s_ma, e);
      if (n == 50) s_inv = ~inv_mode;
      s_rdy = ($urandom_range(0, 99) >= 30);
      if (s_rdy) n++;
      @(negedge clk);
      cyc++;
    end
    chk("sml_beats", n, TOT);
    s_rdy = 1'b0;
    chk("sml_done_cycle", {s_done, s_busy, s_valid, s_last}, 4'b1000);
    if (chain) begin
      s_start = 1'b1;
      s_inv   = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
    end else begin
      @(negedge clk);
      chk("sml_done_pulse", {s_done, s_busy, s_valid}, 3'b000);
    end
  endtask

  initial begin
    b_rst = 1'b1; b_start = 1'b0; b_inv = 1'b0; b_rdy = 1'b0;
    s_rst = 1'b1; s_start = 1'b0; s_inv = 1'b0; s_rdy = 1'b0;
    repeat (3) @(negedge clk);
    b_rst = 1'b0;
    s_rst = 1'b0;
    chk("big_reset", {b_busy, b_valid, b_exp, b_ma, b_stage, b_bfly, b_lane, b_last, b_done}, 0);
    chk("sml_reset", {s_busy, s_valid, s_exp, s_ma, s_stage, s_bfly, s_lane, s_last, s_done}, 0);

    // First beat one cycle after start
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("big_first", {b_busy, b_valid, b_exp, b_ma, b_stage, b_bfly, b_lane}, {2'b11, 50'd0});
    big_run(1'b0, 1000);

    // Reset in the middle of a run
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    b_rdy = 1'b0;
    chk("big_midrst", {b_busy, b_valid, b_exp, b_ma, b_stage, b_bfly, b_lane, b_last, b_done}, 0);
    @(negedge clk);
    chk("big_idle", {b_busy, b_valid, b_done}, 3'b000);

    // Inverse run, inv released mid-run
    b_inv = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    big_run(1'b1, 300);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;

    // Full runs with backpressure; second run starts in the done cycle of the first
    s_start = 1'b1;
    s_inv   = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    sml_run(1'b0, 1'b1);
    sml_run(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
